// File: rtl/fifo_pkg.sv
// Shared helpers for the parametrised FIFO.
// Pointer/count width helper and flag reset values.
package fifo_pkg;

  // Pointer and count width: index bits plus one wrap bit.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam logic FULL_RST   = 1'b0;
  localparam logic EMPTY_RST  = 1'b1;
  localparam logic AFULL_RST  = 1'b0;
  localparam logic AEMPTY_RST = 1'b1;
  localparam logic ERR_RST    = 1'b0;

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: WIDTH x DEPTH, one write port, registered read.
// Ports: clk, reset_n, we/waddr/wdata, re/raddr, rdata.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  localparam int AW = ptr_w(DEPTH) - 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_d, rdata_q;

  // Storage is never reset; only the read register is.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr[AW-1:0]];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdata_q <= '0;
    else          rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with count, thresholds, flush.
// Optional sticky overflow/underflow under SYNC_FIFO_ERR_EN.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       data_out,
  output logic                   rd_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = ptr_w(DEPTH) - 1;
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = ptr_w(DEPTH);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [PW-1:0] wr_ptr_d, wr_ptr_q;
  logic [PW-1:0] rd_ptr_d, rd_ptr_q;
  logic [CW-1:0] count_d, count_q;
  logic          full_d, full_q;
  logic          empty_d, empty_q;
  logic          af_d, af_q;
  logic          ae_d, ae_q;
  logic          rd_valid_d, rd_valid_q;
  logic          wr_acc, rd_acc;

  // Acceptance uses registered flags only.
  assign wr_acc = wr_en & ~full_q;
  assign rd_acc = rd_en & ~empty_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_valid_d = 1'b0;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d    = count_q + CW'(wr_acc) - CW'(rd_acc);
      rd_valid_d = rd_acc;
    end
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_C);
    ae_d    = (count_d <= AE_C);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= FULL_RST;
      empty_q    <= EMPTY_RST;
      af_q       <= AFULL_RST;
      ae_q       <= AEMPTY_RST;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      af_q       <= af_d;
      ae_q       <= ae_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (wr_acc & ~clear),
    .waddr   (wr_ptr_q[AW-1:0]),
    .wdata   (data_in),
    .re      (rd_acc & ~clear),
    .raddr   (rd_ptr_q[AW-1:0]),
    .rdata   (data_out)
  );

`ifdef SYNC_FIFO_ERR_EN
  logic ovf_d, ovf_q;
  logic unf_d, unf_q;

  // Sticky until reset; flush leaves them alone.
  always_comb begin
    ovf_d = ovf_q | (wr_en & full_q);
    unf_d = unf_q | (rd_en & empty_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= ERR_RST;
      unf_q <= ERR_RST;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign rd_valid     = rd_valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (8x16 and 32x64).
// Vector table plus queue scoreboard and corner sequences.
module tb_sync_fifo_param;

`ifdef SYNC_FIFO_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clear, wr_en, rd_en;
  logic [7:0] data_in, data_out;
  logic       rd_valid, full, empty, almost_full, almost_empty;
  logic [4:0] count;
  logic       overflow, underflow;

  logic        w2_en, r2_en;
  logic [31:0] d2_in, d2_out;
  logic        rv2, full2, empty2, af2, ae2, ovf2, unf2;
  logic [6:0]  count2;

  always #5 clk = ~clk;

  sync_fifo_param u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (clear),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .rd_en        (rd_en),
    .data_out     (data_out),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  sync_fifo_param #(.WIDTH(32), .DEPTH(64)) u_dut2 (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (1'b0),
    .wr_en        (w2_en),
    .data_in      (d2_in),
    .rd_en        (r2_en),
    .data_out     (d2_out),
    .rd_valid     (rv2),
    .full         (full2),
    .empty        (empty2),
    .almost_full  (af2),
    .almost_empty (ae2),
    .count        (count2),
    .overflow     (ovf2),
    .underflow    (unf2)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] sb[$];
  int         m_cnt;
  logic [7:0] m_dout;
  bit         m_rv, m_ovf, m_unf;

  typedef struct {
    bit         wr;
    bit         rd;
    bit         clr;
    logic [7:0] din;
    int         cnt;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " count"}, 64'(count), 64'(m_cnt));
    chk({tag, " full"}, 64'(full), 64'(m_cnt == 16));
    chk({tag, " empty"}, 64'(empty), 64'(m_cnt == 0));
    chk({tag, " afull"}, 64'(almost_full), 64'(m_cnt >= 14));
    chk({tag, " aempty"}, 64'(almost_empty), 64'(m_cnt <= 2));
    chk({tag, " rd_valid"}, 64'(rd_valid), 64'(m_rv));
    chk({tag, " data_out"}, 64'(data_out), 64'(m_dout));
    chk({tag, " overflow"}, 64'(overflow), 64'(m_ovf));
    chk({tag, " underflow"}, 64'(underflow), 64'(m_unf));
  endtask

  task automatic model_reset();
    sb.delete();
    m_cnt  = 0;
    m_dout = '0;
    m_rv   = 1'b0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  // One clock: drive, update model at the edge, check at +1.
  task automatic step(input bit wr, input bit rd,
                      input bit clr, input logic [7:0] din,
                      input string tag);
    bit wa, ra;
    wr_en   = wr;
    rd_en   = rd;
    clear   = clr;
    data_in = din;
    @(posedge clk);
    wa = wr && (m_cnt < 16);
    ra = rd && (m_cnt > 0);
    if (ERR && wr && m_cnt == 16) m_ovf = 1'b1;
    if (ERR && rd && m_cnt == 0)  m_unf = 1'b1;
    if (clr) begin
      sb.delete();
      m_cnt = 0;
      m_rv  = 1'b0;
    end else begin
      if (ra) m_dout = sb.pop_front();
      if (wa) sb.push_back(din);
      m_cnt = m_cnt + int'(wa) - int'(ra);
      m_rv  = ra;
    end
    #1;
    check_all(tag);
    wr_en = 1'b0;
    rd_en = 1'b0;
    clear = 1'b0;
  endtask

  logic [31:0] q2[$];
  logic [31:0] e2;

  initial begin
    vecs[0] = '{1, 0, 0, 8'hA1, 1};
    vecs[1] = '{1, 0, 0, 8'hA2, 2};
    vecs[2] = '{1, 1, 0, 8'hA3, 2};
    vecs[3] = '{0, 1, 0, 8'h00, 1};
    vecs[4] = '{0, 1, 0, 8'h00, 0};
    vecs[5] = '{0, 1, 0, 8'h00, 0};
    vecs[6] = '{1, 0, 0, 8'hB1, 1};
    vecs[7] = '{1, 0, 1, 8'hB2, 0};
    vecs[8] = '{1, 1, 0, 8'hC1, 1};
    vecs[9] = '{0, 1, 0, 8'h00, 0};

    reset_n = 1'b0;
    clear   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = '0;
    w2_en   = 1'b0;
    r2_en   = 1'b0;
    d2_in   = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset2 count", 64'(count2), 64'd0);
    chk("reset2 empty", 64'(empty2), 64'd1);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].wr, vecs[i].rd, vecs[i].clr,
           vecs[i].din, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d tbl_count", i),
          64'(count), 64'(vecs[i].cnt));
    end

    for (int i = 0; i < 16; i++)
      step(1, 0, 0, 8'(i), "fill");
    chk("fill full", 64'(full), 64'd1);
    step(1, 0, 0, 8'hEE, "write17");
    chk("write17 ovf", 64'(overflow), 64'(ERR));

    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, 8'h00, "drain");
      chk("drain order", 64'(data_out), 64'(i));
    end
    step(0, 1, 0, 8'h00, "read17");
    chk("read17 hold", 64'(data_out), 64'h0F);

    for (int i = 0; i < 8; i++)
      step(1, 0, 0, 8'(8'h40 + i), "pre8");
    for (int i = 0; i < 40; i++)
      step(1, 1, 0, 8'(8'h50 + i), "sim");
    chk("sim count8", 64'(count), 64'd8);

    for (int i = 0; i < 8; i++)
      step(1, 0, 0, 8'(8'h90 + i), "top");
    step(1, 1, 0, 8'hDD, "fullrw");
    chk("fullrw count", 64'(count), 64'd15);
    chk("fullrw full", 64'(full), 64'd0);

    for (int i = 0; i < 5; i++)
      step(0, 1, 0, 8'h00, "to10");
    chk("to10 count", 64'(count), 64'd10);
    step(1, 0, 1, 8'hCC, "clear");
    step(1, 0, 0, 8'h5A, "postclr_w");
    step(0, 1, 0, 8'h00, "postclr_r");
    chk("postclr data", 64'(data_out), 64'h5A);

    for (int i = 0; i < 5; i++)
      step(1, 0, 0, 8'(8'h70 + i), "burst");
    wr_en = 1'b1;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    #2;
    reset_n = 1'b1;
    wr_en   = 1'b0;
    step(1, 0, 0, 8'h33, "rst_w");
    step(0, 1, 0, 8'h00, "rst_r");
    chk("rst data", 64'(data_out), 64'h33);

    for (int i = 0; i < 64; i++) begin
      w2_en = 1'b1;
      d2_in = 32'hA500_0000 | 32'(i * 7);
      @(posedge clk);
      q2.push_back(d2_in);
      #1;
      if (i == 60) chk("v2 af61", 64'(af2), 64'd0);
      if (i == 61) chk("v2 af62", 64'(af2), 64'd1);
    end
    chk("v2 full", 64'(full2), 64'd1);
    chk("v2 count", 64'(count2), 64'd64);
    d2_in = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    w2_en = 1'b0;
    chk("v2 w65 count", 64'(count2), 64'd64);
    chk("v2 ovf", 64'(ovf2), 64'(ERR));
    r2_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      e2 = q2.pop_front();
      #1;
      chk("v2 rv", 64'(rv2), 64'd1);
      chk("v2 data", 64'(d2_out), 64'(e2));
    end
    chk("v2 empty", 64'(empty2), 64'd1);
    @(posedge clk);
    #1;
    r2_en = 1'b0;
    chk("v2 r65 rv", 64'(rv2), 64'd0);
    chk("v2 unf", 64'(unf2), 64'(ERR));
    chk("v2 hold", 64'(d2_out), 64'(e2));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
